// File: rtl/sensor_packetizer.sv
// Frames 32-bit sensor samples into header/data/checksum byte streams with a one-entry pending buffer.
// Optional sequence byte after the header when SENSOR_PKT_SEQ_EN is defined.
module sensor_packetizer #(
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned GAP_CYCLES  = 16,
    localparam int unsigned DATA_W     = 32,
    localparam int unsigned BYTE_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sensor_data,
    input  logic              sensor_valid,
    input  logic              clear_overrun,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned IDX_W    = 2;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
`ifdef SENSOR_PKT_SEQ_EN
        SEQ  = 3'd2,
`endif
        DATA = 3'd3,
        CSUM = 3'd4,
        GAP  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] frame, frame_nxt;
    logic [DATA_W-1:0] pending, pending_nxt;
    logic              pending_full, pending_full_nxt;
    logic [BYTE_W-1:0] csum, csum_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [BYTE_W-1:0] byte_data_nxt;
    logic              byte_valid_nxt;
    logic              busy_nxt;
    logic              overrun_nxt;
    logic              accept;
    logic              launch_ok;
    logic              direct_load;
`ifdef SENSOR_PKT_SEQ_EN
    logic [BYTE_W-1:0] seq, seq_nxt;
`endif

    // Data bytes leave MSB first
    function automatic logic [BYTE_W-1:0] frame_byte(input logic [DATA_W-1:0] word,
                                                     input logic [IDX_W-1:0]  sel);
        logic [BYTE_W-1:0] res;
        case (sel)
            2'd0:    res = word[31:24];
            2'd1:    res = word[23:16];
            2'd2:    res = word[15:8];
            default: res = word[7:0];
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            frame        <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            csum         <= '0;
            idx          <= '0;
            gap_cnt      <= '0;
            byte_data    <= '0;
            byte_valid   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef SENSOR_PKT_SEQ_EN
            seq          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            frame        <= frame_nxt;
            pending      <= pending_nxt;
            pending_full <= pending_full_nxt;
            csum         <= csum_nxt;
            idx          <= idx_nxt;
            gap_cnt      <= gap_cnt_nxt;
            byte_data    <= byte_data_nxt;
            byte_valid   <= byte_valid_nxt;
            busy         <= busy_nxt;
            overrun      <= overrun_nxt;
`ifdef SENSOR_PKT_SEQ_EN
            seq          <= seq_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt        = state;
        frame_nxt        = frame;
        pending_nxt      = pending;
        pending_full_nxt = pending_full;
        csum_nxt         = csum;
        idx_nxt          = idx;
        gap_cnt_nxt      = gap_cnt;
        byte_data_nxt    = byte_data;
        byte_valid_nxt   = byte_valid;
        overrun_nxt      = overrun;
        launch_ok        = 1'b0;
        direct_load      = 1'b0;
        accept           = byte_valid & byte_ready;
`ifdef SENSOR_PKT_SEQ_EN
        seq_nxt          = seq;
`endif

        case (state)
            IDLE: launch_ok = 1'b1;
            HDR: begin
                if (accept) begin
`ifdef SENSOR_PKT_SEQ_EN
                    state_nxt     = SEQ;
                    byte_data_nxt = seq;
`else
                    state_nxt     = DATA;
                    idx_nxt       = '0;
                    byte_data_nxt = frame_byte(frame, IDX_W'(0));
`endif
                end
            end
`ifdef SENSOR_PKT_SEQ_EN
            SEQ: begin
                if (accept) begin
                    csum_nxt      = csum + byte_data;
                    seq_nxt       = seq + BYTE_W'(1);
                    state_nxt     = DATA;
                    idx_nxt       = '0;
                    byte_data_nxt = frame_byte(frame, IDX_W'(0));
                end
            end
`endif
            DATA: begin
                if (accept) begin
                    csum_nxt = csum + byte_data;
                    if (idx == IDX_W'(3)) begin
                        state_nxt     = CSUM;
                        byte_data_nxt = csum + byte_data;
                    end else begin
                        idx_nxt       = idx + IDX_W'(1);
                        byte_data_nxt = frame_byte(frame, idx + IDX_W'(1));
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    byte_valid_nxt = 1'b0;
                    gap_cnt_nxt    = '0;
                    state_nxt      = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                // Final gap cycle doubles as the launch slot so the quiet time is exactly GAP_CYCLES
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_nxt = IDLE;
                    launch_ok = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (launch_ok && (pending_full || sensor_valid)) begin
            if (pending_full) begin
                frame_nxt        = pending;
                pending_full_nxt = 1'b0;
            end else begin
                frame_nxt   = sensor_data;
                direct_load = 1'b1;
            end
            state_nxt      = HDR;
            csum_nxt       = '0;
            idx_nxt        = '0;
            byte_valid_nxt = 1'b1;
            byte_data_nxt  = HEADER_BYTE;
        end

        if (clear_overrun) begin
            overrun_nxt = 1'b0;
        end

        // A sample not taken straight into the frame lands in pending
        if (sensor_valid && !direct_load) begin
            pending_nxt      = sensor_data;
            pending_full_nxt = 1'b1;
            if (pending_full && !launch_ok) begin
                overrun_nxt = 1'b1;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
